// File: rtl/pipe_adder_tree_accum.sv
// Streaming N-ary pipelined adder tree followed by a packet accumulator.
// Each beat of NUM_ELEMENTS terms is reduced to one sum, and the sums are accumulated from sop to eop.
module pipe_adder_tree_accum #(
    parameter int NUM_ELEMENTS    = 8,
    parameter int BIT_LEN         = 16,
    parameter int N               = 4,
    parameter int STAGES_PER_PIPE = 1,
    parameter int CTL_BITS        = 8,
    parameter int ACC_GROW        = 8,
    parameter int SIGNED          = 0,
    parameter int BEAT_BITS       = 8,
    parameter int OUT_LEN         = BIT_LEN + $clog2(NUM_ELEMENTS) + ACC_GROW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BIT_LEN-1:0]   i_terms [NUM_ELEMENTS],
    input  logic                 i_val,
    input  logic                 i_sop,
    input  logic                 i_eop,
    input  logic [CTL_BITS-1:0]  i_ctl,
    output logic                 o_rdy,
    input  logic                 i_rdy,
    output logic                 o_val,
    output logic [OUT_LEN-1:0]   o_s,
    output logic [CTL_BITS-1:0]  o_ctl,
    output logic [BEAT_BITS-1:0] o_beats,
    output logic                 o_err
);

    function automatic int next_cnt(input int m);
        return (m < N) ? 1 : (m / N) + (m % N);
    endfunction

    function automatic int cnt_at(input int k);
        int m;
        m = NUM_ELEMENTS;
        for (int i = 0; i < k; i++) m = next_cnt(m);
        return m;
    endfunction

    function automatic int calc_levels();
        int m;
        int l;
        m = next_cnt(NUM_ELEMENTS);
        l = 1;
        while (m > 1) begin
            m = next_cnt(m);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels();

    logic               stall;
    logic [OUT_LEN-1:0] ext_w [NUM_ELEMENTS];

    // A stalled result freezes the entire datapath, so upstream sees o_rdy low.
    assign stall = o_val & ~i_rdy;
    assign o_rdy = ~stall;

    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_ext
        if (SIGNED != 0) begin : g_sx
            assign ext_w[j] = OUT_LEN'($signed(i_terms[j]));
        end else begin : g_zx
            assign ext_w[j] = OUT_LEN'(i_terms[j]);
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int M_IN  = cnt_at(k - 1);
        localparam int M_OUT = cnt_at(k);

        logic [OUT_LEN-1:0]  in_w  [M_IN];
        logic [OUT_LEN-1:0]  sum_d [M_OUT];
        logic [OUT_LEN-1:0]  out_w [M_OUT];
        logic                in_val_w, in_sop_w, in_eop_w;
        logic                out_val_w, out_sop_w, out_eop_w;
        logic [CTL_BITS-1:0] in_ctl_w, out_ctl_w;

        if (k == 1) begin : g_src
            assign in_w     = ext_w;
            assign in_val_w = i_val & o_rdy;
            assign in_sop_w = i_sop;
            assign in_eop_w = i_eop;
            assign in_ctl_w = i_ctl;
        end else begin : g_src
            assign in_w     = g_lvl[k-1].out_w;
            assign in_val_w = g_lvl[k-1].out_val_w;
            assign in_sop_w = g_lvl[k-1].out_sop_w;
            assign in_eop_w = g_lvl[k-1].out_eop_w;
            assign in_ctl_w = g_lvl[k-1].out_ctl_w;
        end

        if (M_IN < N) begin : g_final
            always_comb begin
                sum_d[0] = '0;
                for (int j = 0; j < M_IN; j++) sum_d[0] = sum_d[0] + in_w[j];
            end
        end else begin : g_group
            localparam int G = M_IN / N;
            // Full groups of N are summed; leftover terms pass through untouched.
            always_comb begin
                for (int g = 0; g < G; g++) begin
                    sum_d[g] = '0;
                    for (int j = 0; j < N; j++) sum_d[g] = sum_d[g] + in_w[g*N + j];
                end
                for (int j = 0; j < M_IN % N; j++) sum_d[G + j] = in_w[G*N + j];
            end
        end

        if ((k % STAGES_PER_PIPE == 0) || (k == LEVELS)) begin : g_reg
            logic [OUT_LEN-1:0]  sum_q [M_OUT];
            logic                val_q, sop_q, eop_q;
            logic [CTL_BITS-1:0] ctl_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int g = 0; g < M_OUT; g++) sum_q[g] <= '0;
                    val_q <= 1'b0;
                    sop_q <= 1'b0;
                    eop_q <= 1'b0;
                    ctl_q <= '0;
                end else if (!stall) begin
                    sum_q <= sum_d;
                    val_q <= in_val_w;
                    sop_q <= in_sop_w;
                    eop_q <= in_eop_w;
                    ctl_q <= in_ctl_w;
                end
            end

            assign out_w     = sum_q;
            assign out_val_w = val_q;
            assign out_sop_w = sop_q;
            assign out_eop_w = eop_q;
            assign out_ctl_w = ctl_q;
        end else begin : g_comb
            assign out_w     = sum_d;
            assign out_val_w = in_val_w;
            assign out_sop_w = in_sop_w;
            assign out_eop_w = in_eop_w;
            assign out_ctl_w = in_ctl_w;
        end
    end

    logic                 t_val, t_sop, t_eop;
    logic [OUT_LEN-1:0]   t_sum;
    logic [CTL_BITS-1:0]  t_ctl;

    assign t_val = g_lvl[LEVELS].out_val_w;
    assign t_sop = g_lvl[LEVELS].out_sop_w;
    assign t_eop = g_lvl[LEVELS].out_eop_w;
    assign t_sum = g_lvl[LEVELS].out_w[0];
    assign t_ctl = g_lvl[LEVELS].out_ctl_w;

    logic [OUT_LEN-1:0]   acc_q, acc_d, out_s_q, out_s_d;
    logic [BEAT_BITS-1:0] beats_q, beats_d, out_beats_q, out_beats_d;
    logic [CTL_BITS-1:0]  ctl_q, ctl_d, out_ctl_q, out_ctl_d;
    logic                 err_q, err_d, open_q, open_d;
    logic                 out_val_q, out_val_d, out_err_q, out_err_d;

    always_comb begin
        acc_d       = acc_q;
        beats_d     = beats_q;
        ctl_d       = ctl_q;
        err_d       = err_q;
        open_d      = open_q;
        out_val_d   = out_val_q;
        out_s_d     = out_s_q;
        out_ctl_d   = out_ctl_q;
        out_beats_d = out_beats_q;
        out_err_d   = out_err_q;
        if (!stall) begin
            out_val_d = 1'b0;
            if (t_val) begin
                // A beat without an open packet starts one, flagged as a framing error unless it carries sop.
                if (t_sop || !open_q) begin
                    acc_d   = t_sum;
                    beats_d = BEAT_BITS'(1);
                    err_d   = open_q | ~t_sop;
                    ctl_d   = t_ctl;
                end else begin
                    acc_d   = acc_q + t_sum;
                    beats_d = (&beats_q) ? beats_q : beats_q + BEAT_BITS'(1);
                end
                open_d = ~t_eop;
                if (t_eop) begin
                    out_val_d   = 1'b1;
                    out_s_d     = acc_d;
                    out_ctl_d   = ctl_d;
                    out_beats_d = beats_d;
                    out_err_d   = err_d;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q       <= '0;
            beats_q     <= '0;
            ctl_q       <= '0;
            err_q       <= 1'b0;
            open_q      <= 1'b0;
            out_val_q   <= 1'b0;
            out_s_q     <= '0;
            out_ctl_q   <= '0;
            out_beats_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ctl_q       <= ctl_d;
            err_q       <= err_d;
            open_q      <= open_d;
            out_val_q   <= out_val_d;
            out_s_q     <= out_s_d;
            out_ctl_q   <= out_ctl_d;
            out_beats_q <= out_beats_d;
            out_err_q   <= out_err_d;
        end
    end

    assign o_val   = out_val_q;
    assign o_s     = out_s_q;
    assign o_ctl   = out_ctl_q;
    assign o_beats = out_beats_q;
    assign o_err   = out_err_q;

endmodule
